// File: rtl/mem_access_unit.sv
// Memory-access pipeline stage: one outstanding data-memory op, stalling EX/M until ack.
// Optional feature macro MEM_TIMEOUT_EN aborts an op after TIMEOUT_CYCLES BUSY cycles without ack.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        Valid_in,
    input  logic [1:0]  Memory_in,
    input  logic [15:0] ALU_in,
    input  logic [15:0] Memory_data_write_in,
    input  logic [15:0] Zero_pad_in,
    input  logic [15:0] PC_plus1_in,
    input  logic [2:0]  WB_in,
    input  logic [2:0]  Dest_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [15:0] dmem_rdata,
    output logic        stall_out,
    output logic        Valid_out,
    output logic [2:0]  WB_out,
    output logic [2:0]  Dest_out,
    output logic [15:0] Result_out,
    output logic [15:0] Zero_pad_out,
    output logic [15:0] PC_plus1_out,
    output logic        mem_err_out
);
    // state | meaning
    // IDLE  | accepting a new EX/M instruction
    // BUSY  | data-memory request outstanding, waiting for dmem_ack

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t state, state_next;
    logic   mem_op, accept, pass, finish, abort, stall_comb;

    assign mem_op = (Memory_in == 2'b10) || (Memory_in == 2'b01);

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] busy_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            busy_cnt <= '0;
        else if (accept)
            busy_cnt <= TMO_LOAD;
        else if (state == BUSY && busy_cnt != '0)
            busy_cnt <= busy_cnt - 8'd1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        pass       = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        stall_comb = 1'b0;
        case (state)
            IDLE: begin
                if (Valid_in) begin
                    if (mem_op) begin
                        accept     = 1'b1;
                        stall_comb = 1'b1;
                        state_next = BUSY;
                    end else begin
                        pass = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (busy_cnt == '0) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end
`endif
                else begin
                    stall_comb = 1'b1;
                end
            end
        endcase
    end

    // Stall is gated by reset so upstream is never frozen while the stage is held in reset.
    assign stall_out = reset & stall_comb;

    // The request fields double as the latched op: dmem_we marks a store, dmem_addr holds the ALU value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            Valid_out    <= 1'b0;
            mem_err_out  <= 1'b0;
            WB_out       <= '0;
            Dest_out     <= '0;
            Result_out   <= '0;
            Zero_pad_out <= '0;
            PC_plus1_out <= '0;
        end else begin
            Valid_out   <= pass | finish;
            mem_err_out <= (pass && Memory_in == 2'b11) || abort;
            if (accept) begin
                dmem_req   <= 1'b1;
                dmem_we    <= (Memory_in == 2'b01);
                dmem_addr  <= ALU_in;
                dmem_wdata <= Memory_data_write_in;
            end
            if (accept || pass) begin
                WB_out       <= WB_in;
                Dest_out     <= Dest_in;
                Zero_pad_out <= Zero_pad_in;
                PC_plus1_out <= PC_plus1_in;
            end
            if (pass)
                Result_out <= ALU_in;
            if (finish)
                Result_out <= dmem_we ? dmem_addr : dmem_rdata;
            if (finish || abort) begin
                dmem_req <= 1'b0;
                dmem_we  <= 1'b0;
            end
        end
    end

endmodule
